// File: rtl/pmips_pkg.sv
//------------------------------------------------------------------------------
// pmips_pkg
//------------------------------------------------------------------------------
// Shared encodings for the 16-bit pmips multicycle core: opcode values, the
// control-FSM state codes, and the select encodings driven onto the datapath
// (ALU operation, ALU B-input source, PC source). Also holds the packed
// control-word type used by the control unit to build its outputs.
//
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package pmips_pkg;

    // Opcode field values (instr[15:13]); 6 and 7 are unassigned.
    localparam logic [2:0] c_OP_RTYPE = 3'd0;
    localparam logic [2:0] c_OP_J     = 3'd1;
    localparam logic [2:0] c_OP_BEQ   = 3'd2;
    localparam logic [2:0] c_OP_ADDI  = 3'd3;
    localparam logic [2:0] c_OP_LW    = 3'd4;
    localparam logic [2:0] c_OP_SW    = 3'd5;

    // Control FSM state codes. The numeric values are exported on the debug
    // state port, so keep them stable once boards depend on the LED pattern.
    typedef logic [3:0] state_t;
    localparam state_t c_S_FETCH    = 4'd0;
    localparam state_t c_S_DECODE   = 4'd1;
    localparam state_t c_S_EXEC_R   = 4'd2;
    localparam state_t c_S_WB_R     = 4'd3;
    localparam state_t c_S_EXEC_I   = 4'd4;
    localparam state_t c_S_WB_I     = 4'd5;
    localparam state_t c_S_BRANCH   = 4'd6;
    localparam state_t c_S_JUMP     = 4'd7;
    localparam state_t c_S_MEM_ADDR = 4'd8;
    localparam state_t c_S_MEM_RD   = 4'd9;
    localparam state_t c_S_MEM_WR   = 4'd10;
    localparam state_t c_S_WB_MEM   = 4'd11;

    // ALU operation select.
    localparam logic [1:0] c_ALU_ADD   = 2'd0;
    localparam logic [1:0] c_ALU_SUB   = 2'd1;
    localparam logic [1:0] c_ALU_FUNCT = 2'd2;

    // ALU B-input source select.
    localparam logic [1:0] c_SRCB_RT     = 2'd0;
    localparam logic [1:0] c_SRCB_TWO    = 2'd1;
    localparam logic [1:0] c_SRCB_IMM    = 2'd2;
    localparam logic [1:0] c_SRCB_IMM_SH = 2'd3;

    // PC source select.
    localparam logic [1:0] c_PC_ALU    = 2'd0;
    localparam logic [1:0] c_PC_ALUOUT = 2'd1;
    localparam logic [1:0] c_PC_JUMP   = 2'd2;

    // One bundle for every control line; zero is the "do nothing" word.
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
    } ctrl_t;

endpackage : pmips_pkg

`default_nettype wire

// File: rtl/mc_control.sv
//------------------------------------------------------------------------------
// mc_control
//------------------------------------------------------------------------------
// Multicycle control unit for the 16-bit pmips core. Sequences the shared ALU,
// instruction register and single memory port through fetch, decode, execute,
// memory and write-back steps, with memory wait-state handshaking and a
// run/halt gate for single-stepping.
//
// Parameters
//   OP_W        opcode field width, taken from the top of instr
//   STATE_W     width of the exported state code
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   run         1 = allow new fetches; sampled only in FETCH
//   instr       instruction register contents
//   alu_zero    ALU result is zero (branch compare)
//   mem_ready   memory port completes the current access this cycle
//   pc_write, ir_write, mem_read, mem_write, reg_write   strobes
//   iord        memory address: 0 = PC, 1 = ALUOut
//   reg_dst     write register: 0 = rt, 1 = rd
//   mem_to_reg  write-back data: 0 = ALUOut, 1 = MDR
//   alu_src_a   0 = PC, 1 = rs
//   alu_src_b   0 = rt, 1 = 2, 2 = sext(imm7), 3 = sext(imm7)<<1
//   alu_op      0 = add, 1 = sub, 2 = by funct
//   pc_src      0 = ALU result, 1 = ALUOut, 2 = jump target
//   illegal     one-cycle pulse in DECODE on an unassigned opcode
//   state       current FSM state code
//
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module mc_control
    import pmips_pkg::*;
#(
    parameter int OP_W    = 3,
    parameter int STATE_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic [15:0]        instr,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic               iord,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    state_t           r_state;
    state_t           w_next;
    ctrl_t            w_ctl;
    ctrl_t            w_ctl_out;
    logic [OP_W-1:0]  w_opcode;
    logic             w_unused_instr;

    assign w_opcode = instr[15 -: OP_W];

    // Operand fields are decoded in the datapath, not here.
    assign w_unused_instr = ^instr[15-OP_W:0];

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and control decode
    //--------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        w_ctl  = '0;

        case (r_state)
            c_S_FETCH: begin
                // With run low the FSM parks here without touching memory,
                // so a halted board sees a completely quiet bus.
                if (run) begin
                    w_ctl.mem_read = 1'b1;
                    w_ctl.iord     = 1'b0;
                    if (mem_ready) begin
                        w_ctl.ir_write  = 1'b1;
                        w_ctl.pc_write  = 1'b1;
                        w_ctl.alu_src_a = 1'b0;
                        w_ctl.alu_src_b = c_SRCB_TWO;
                        w_ctl.alu_op    = c_ALU_ADD;
                        w_ctl.pc_src    = c_PC_ALU;
                        w_next          = c_S_DECODE;
                    end
                end
            end

            c_S_DECODE: begin
                // Branch target is computed speculatively into ALUOut so that
                // BRANCH only needs the compare cycle.
                w_ctl.alu_src_a = 1'b0;
                w_ctl.alu_src_b = c_SRCB_IMM_SH;
                w_ctl.alu_op    = c_ALU_ADD;
                case (w_opcode)
                    OP_W'(c_OP_RTYPE): w_next = c_S_EXEC_R;
                    OP_W'(c_OP_ADDI):  w_next = c_S_EXEC_I;
                    OP_W'(c_OP_BEQ):   w_next = c_S_BRANCH;
                    OP_W'(c_OP_J):     w_next = c_S_JUMP;
                    OP_W'(c_OP_LW):    w_next = c_S_MEM_ADDR;
                    OP_W'(c_OP_SW):    w_next = c_S_MEM_ADDR;
                    default: begin
                        // Unassigned opcode: flag it and retire as a NOP.
                        w_ctl.illegal = 1'b1;
                        w_next        = c_S_FETCH;
                    end
                endcase
            end

            c_S_EXEC_R: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = c_SRCB_RT;
                w_ctl.alu_op    = c_ALU_FUNCT;
                w_next          = c_S_WB_R;
            end

            c_S_WB_R: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.reg_dst    = 1'b1;
                w_ctl.mem_to_reg = 1'b0;
                w_next           = c_S_FETCH;
            end

            c_S_EXEC_I: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = c_SRCB_IMM;
                w_ctl.alu_op    = c_ALU_ADD;
                w_next          = c_S_WB_I;
            end

            c_S_WB_I: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.reg_dst    = 1'b0;
                w_ctl.mem_to_reg = 1'b0;
                w_next           = c_S_FETCH;
            end

            c_S_BRANCH: begin
                // rs - rt; PC takes the target held in ALUOut only if equal.
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = c_SRCB_RT;
                w_ctl.alu_op    = c_ALU_SUB;
                w_ctl.pc_src    = c_PC_ALUOUT;
                w_ctl.pc_write  = alu_zero;
                w_next          = c_S_FETCH;
            end

            c_S_JUMP: begin
                w_ctl.pc_src   = c_PC_JUMP;
                w_ctl.pc_write = 1'b1;
                w_next         = c_S_FETCH;
            end

            c_S_MEM_ADDR: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = c_SRCB_IMM;
                w_ctl.alu_op    = c_ALU_ADD;
                if (w_opcode == OP_W'(c_OP_SW)) begin
                    w_next = c_S_MEM_WR;
                end else if (w_opcode == OP_W'(c_OP_LW)) begin
                    w_next = c_S_MEM_RD;
                end else begin
                    w_next = c_S_FETCH;
                end
            end

            c_S_MEM_RD: begin
                // Address and strobe stay put for the whole wait.
                w_ctl.iord     = 1'b1;
                w_ctl.mem_read = 1'b1;
                if (mem_ready) begin
                    w_next = c_S_WB_MEM;
                end
            end

            c_S_MEM_WR: begin
                w_ctl.iord      = 1'b1;
                w_ctl.mem_write = 1'b1;
                if (mem_ready) begin
                    w_next = c_S_FETCH;
                end
            end

            c_S_WB_MEM: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.reg_dst    = 1'b0;
                w_ctl.mem_to_reg = 1'b1;
                w_next           = c_S_FETCH;
            end

            default: begin
                w_next = c_S_FETCH;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    // The state register clears asynchronously, but run may still be high
    // while reset is held; gating here keeps every line quiet during reset.
    assign w_ctl_out = reset ? w_ctl : '0;

    assign pc_write   = w_ctl_out.pc_write;
    assign ir_write   = w_ctl_out.ir_write;
    assign mem_read   = w_ctl_out.mem_read;
    assign mem_write  = w_ctl_out.mem_write;
    assign reg_write  = w_ctl_out.reg_write;
    assign iord       = w_ctl_out.iord;
    assign reg_dst    = w_ctl_out.reg_dst;
    assign mem_to_reg = w_ctl_out.mem_to_reg;
    assign alu_src_a  = w_ctl_out.alu_src_a;
    assign alu_src_b  = w_ctl_out.alu_src_b;
    assign alu_op     = w_ctl_out.alu_op;
    assign pc_src     = w_ctl_out.pc_src;
    assign illegal    = w_ctl_out.illegal;

    assign state = STATE_W'(r_state);

endmodule : mc_control

`default_nettype wire
